// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator RAM and the blocks that talk to it.
package accum_pkg;

    typedef enum logic [1:0] {
        READ       = 2'd0,
        WRITE      = 2'd1,
        WRITE_OVER = 2'd2,
        DISABLE    = 2'd3
    } accum_request_t;

    localparam int RAM_READ_LATENCY = 2;

endpackage

// File: rtl/accum_result_fifo.sv
// Result buffer for the scanner: synchronous FIFO with registered head word and
// occupancy count. FIFO_DEPTH must be a power of two.
module accum_result_fifo #(
    parameter int WIDTH      = 8,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              push_in,
    input  logic [WIDTH-1:0]  push_data_in,
    input  logic [ADDR_W-1:0] push_addr_in,
    input  logic              ready_in,
    output logic              valid_out,
    output logic [WIDTH-1:0]  data_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic [CW-1:0]     count_out
);

    localparam int EW = WIDTH + ADDR_W;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_next;
    logic [CW-1:0] count_q, count_next, count_after_pop;
    logic [EW-1:0] head_q, head_next, push_word;
    logic          valid_q, pop, wr_en;

    always_comb begin
        push_word       = {push_data_in, push_addr_in};
        pop             = valid_q && ready_in;
        count_after_pop = count_q - CW'(pop);
        wr_en           = push_in && (count_after_pop != CW'(FIFO_DEPTH));
        count_next      = count_after_pop + CW'(wr_en);
        rd_ptr_next     = rd_ptr_q + PW'(pop);
        head_next       = head_q;
        // An entry written into an otherwise empty buffer bypasses straight to the head.
        if (wr_en && (count_after_pop == '0)) begin
            head_next = push_word;
        end else if (count_after_pop != '0) begin
            head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            count_q  <= '0;
            valid_q  <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            count_q  <= count_next;
            valid_q  <= (count_next != '0);
            rd_ptr_q <= rd_ptr_next;
            head_q   <= head_next;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= push_word;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = head_q[EW-1:ADDR_W];
    assign addr_out  = head_q[ADDR_W-1:0];
    assign count_out = count_q;

endmodule

// File: rtl/accum_ram_scanner.sv
// Sweeps every accumulator address, streams returned words as (address, code) pairs.
// Build option: SCAN_CLEAR_ON_READ_EN issues WRITE_OVER (read-and-clear) instead of READ.
module accum_ram_scanner
    import accum_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 256,
    parameter int FIFO_DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           start_in,
    output logic           busy_out,
    output logic           done_out,
    output logic [AW-1:0]  req_addr_out,
    output accum_request_t req_type_out,
    output logic           req_summand_out,
    output logic           req_valid_out,
    input  logic [WIDTH-1:0] ret_data_in,
    input  logic [AW-1:0]  ret_addr_in,
    input  accum_request_t ret_type_in,
    input  logic           ret_valid_in,
    output logic [WIDTH-1:0] code_out,
    output logic [AW-1:0]  code_addr_out,
    output logic           code_disabled_out,
    output logic           code_valid_out,
    input  logic           code_ready_in
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

`ifdef SCAN_CLEAR_ON_READ_EN
    localparam accum_request_t SCAN_TYPE = WRITE_OVER;
`else
    localparam accum_request_t SCAN_TYPE = READ;
`endif

    localparam int IFW = $clog2(RAM_READ_LATENCY + 2);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam int OCW = FCW + 1;

    logic [1:0]     state_q;
    logic [AW:0]    addr_cnt_q, cnt_base, cnt_inc;
    logic [IFW-1:0] in_flight_q;
    logic [FCW-1:0] fifo_count;
    logic [OCW-1:0] occupancy;
    logic           capture_p0, pop, credit_ok, issue_p0, drained;

    always_comb begin
        capture_p0 = ret_valid_in && (ret_type_in == SCAN_TYPE) && (in_flight_q != '0);
        pop        = code_valid_out && code_ready_in;
        // A slot freed by this cycle's pop can be re-issued at the same edge.
        occupancy  = OCW'(in_flight_q) + OCW'(fifo_count) - OCW'(pop);
        credit_ok  = occupancy < OCW'(FIFO_DEPTH);
        issue_p0   = credit_ok && ((state_q == ISSUE) || ((state_q == IDLE) && start_in));
        cnt_base   = (state_q == IDLE) ? '0 : addr_cnt_q;
        cnt_inc    = cnt_base + (AW+1)'(issue_p0);
        drained    = (in_flight_q == '0) && ((fifo_count - FCW'(pop)) == '0);
    end

    // Request stage: registered toward the RAM, all fields move together.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= IDLE;
            addr_cnt_q    <= '0;
            in_flight_q   <= '0;
            req_valid_out <= 1'b0;
            req_addr_out  <= '0;
            req_type_out  <= READ;
        end else begin
            req_valid_out <= issue_p0;
            if (issue_p0) begin
                req_addr_out <= cnt_base[AW-1:0];
                req_type_out <= SCAN_TYPE;
            end
            in_flight_q <= in_flight_q + IFW'(issue_p0) - IFW'(capture_p0);
            case (state_q)
                IDLE: begin
                    if (start_in) begin
                        addr_cnt_q <= cnt_inc;
                        state_q    <= (cnt_inc == (AW+1)'(DEPTH)) ? DRAIN : ISSUE;
                    end
                end
                ISSUE: begin
                    addr_cnt_q <= cnt_inc;
                    if (cnt_inc == (AW+1)'(DEPTH)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Capture stage: returned words land in the result buffer.
    accum_result_fifo #(
        .WIDTH      (WIDTH),
        .ADDR_W     (AW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .push_in      (capture_p0),
        .push_data_in (ret_data_in),
        .push_addr_in (ret_addr_in),
        .ready_in     (code_ready_in),
        .valid_out    (code_valid_out),
        .data_out     (code_out),
        .addr_out     (code_addr_out),
        .count_out    (fifo_count)
    );

    assign busy_out          = (state_q != IDLE);
    assign done_out          = (state_q == DONE);
    assign req_summand_out   = 1'b0;
    assign code_disabled_out = &code_out;

endmodule

// File: tb/tb_accum_ram_scanner.sv
// Directed bench for accum_ram_scanner with a 2-cycle accumulator RAM model.
module tb_accum_ram_scanner;
    import accum_pkg::*;

    localparam int WIDTH = 8, DEPTH = 16, FIFO_DEPTH = 4, AW = 4;
`ifdef SCAN_CLEAR_ON_READ_EN
    localparam accum_request_t EXP_TYPE = WRITE_OVER;
`else
    localparam accum_request_t EXP_TYPE = READ;
`endif

    logic clk = 1'b0;
    logic rst_in = 1'b0;
    logic start_in = 1'b0;
    logic code_ready_in = 1'b1;
    logic busy_out, done_out, req_summand_out, req_valid_out;
    logic [AW-1:0] req_addr_out, code_addr_out;
    accum_request_t req_type_out;
    logic [WIDTH-1:0] ret_data_in = '0;
    logic [AW-1:0] ret_addr_in = '0;
    accum_request_t ret_type_in = READ;
    logic ret_valid_in = 1'b0;
    logic [WIDTH-1:0] code_out;
    logic code_disabled_out, code_valid_out;

    always #5 clk = ~clk;

    accum_ram_scanner #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_in(clk), .rst_in(rst_in), .start_in(start_in),
        .busy_out(busy_out), .done_out(done_out),
        .req_addr_out(req_addr_out), .req_type_out(req_type_out),
        .req_summand_out(req_summand_out), .req_valid_out(req_valid_out),
        .ret_data_in(ret_data_in), .ret_addr_in(ret_addr_in),
        .ret_type_in(ret_type_in), .ret_valid_in(ret_valid_in),
        .code_out(code_out), .code_addr_out(code_addr_out),
        .code_disabled_out(code_disabled_out), .code_valid_out(code_valid_out),
        .code_ready_in(code_ready_in)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // RAM model: request sampled one edge after it is driven, word returned the edge after.
    logic [WIDTH-1:0] mem [DEPTH];
    int gen = 1;
    int clr_gen [DEPTH];
    logic foreign_en = 1'b0;
    logic s1_v = 1'b0;
    logic [AW-1:0] s1_a = '0;
    accum_request_t s1_t = READ;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        s1_v <= req_valid_out;
        s1_a <= req_addr_out;
        s1_t <= req_type_out;
        if (s1_v) begin
            ret_valid_in <= 1'b1;
            ret_addr_in  <= s1_a;
            ret_type_in  <= s1_t;
            ret_data_in  <= (clr_gen[s1_a] == gen) ? '0 : mem[s1_a];
            if (s1_t == WRITE_OVER) clr_gen[s1_a] <= gen;
        end else if (foreign_en) begin
            ret_valid_in <= 1'b1;
            ret_addr_in  <= 4'd3;
            ret_type_in  <= WRITE;
            ret_data_in  <= 8'hAA;
        end else begin
            ret_valid_in <= 1'b0;
        end
    end

    // Stream monitor: statistics restart whenever a new sweep id appears.
    int sweep_id = 0, seen_id = 0, sweep_t0 = 0;
    logic [WIDTH-1:0] got_data [$];
    logic [AW-1:0] got_addr [$];
    logic got_dis [$];
    int issued, accepted, max_out, done_cnt, done_cyc, first_code;
    accum_request_t last_type;

    always @(negedge clk) begin
        if (seen_id != sweep_id) begin
            seen_id = sweep_id;
            got_data.delete(); got_addr.delete(); got_dis.delete();
            issued = 0; accepted = 0; max_out = 0; done_cnt = 0; done_cyc = -1; first_code = -1;
            last_type = READ;
        end
        if (rst_in) begin
            if (req_valid_out) begin
                issued++;
                last_type = req_type_out;
            end
            if (code_valid_out && first_code < 0) first_code = cyc - sweep_t0;
            if (code_valid_out && code_ready_in) begin
                got_data.push_back(code_out);
                got_addr.push_back(code_addr_out);
                got_dis.push_back(code_disabled_out);
                accepted++;
            end
            if (issued - accepted > max_out) max_out = issued - accepted;
            if (done_out) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    int busy_log [64];

    // Stimulus only: pulses start, shapes ready, runs until done plus settle time.
    task automatic do_sweep(input int mode, input int mid_start, output int done_rel);
        int rel;
        @(posedge clk); #1;
        sweep_id++;
        sweep_t0 = cyc;
        start_in = 1'b1;
        rel = 0;
        busy_log[0] = busy_out;
        while ((rel < 26 || done_cnt == 0) && rel < 400) begin
            @(posedge clk); #1;
            rel = cyc - sweep_t0;
            start_in = (rel == mid_start);
            case (mode)
                1: code_ready_in = !(rel >= 6 && rel < 16);
                2: code_ready_in = (rel % 2 == 0);
                default: code_ready_in = 1'b1;
            endcase
            if (rel < 64) busy_log[rel] = busy_out;
        end
        start_in = 1'b0;
        code_ready_in = 1'b1;
        done_rel = (done_cnt > 0) ? done_cyc - sweep_t0 : -1;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_out); end
        checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_out); end
        checks++; if (req_valid_out !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", req_valid_out); end
        checks++; if (req_addr_out !== '0) begin errors++; $display("FAIL reset_req_addr: got %0d want 0", req_addr_out); end
        checks++; if (req_type_out !== READ) begin errors++; $display("FAIL reset_req_type: got %0d want %0d", req_type_out, READ); end
        checks++; if (req_summand_out !== 1'b0) begin errors++; $display("FAIL reset_summand: got %b want 0", req_summand_out); end
        checks++; if (code_valid_out !== 1'b0) begin errors++; $display("FAIL reset_code_valid: got %b want 0", code_valid_out); end
        checks++; if (code_out !== '0 || code_addr_out !== '0 || code_disabled_out !== 1'b0) begin
            errors++; $display("FAIL reset_code: got %h/%0d/%b want 0/0/0", code_out, code_addr_out, code_disabled_out);
        end
        rst_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy_out !== 1'b0 || req_valid_out !== 1'b0) begin
            errors++; $display("FAIL idle_no_start: busy %b req_valid %b want 0 0", busy_out, req_valid_out);
        end
    endtask

    task automatic test_clean_sweep();
        int d, nd;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
        gen++;
        do_sweep(0, -1, d);
        checks++; if (d !== 20) begin errors++; $display("FAIL clean_done_cycle: got %0d want 20", d); end
        checks++; if (first_code !== 4) begin errors++; $display("FAIL clean_first_code_cycle: got %0d want 4", first_code); end
        checks++; if (busy_log[0] !== 0 || busy_log[1] !== 1 || busy_log[20] !== 1 || busy_log[21] !== 0) begin
            errors++; $display("FAIL clean_busy: got %0d%0d%0d%0d want 0110", busy_log[0], busy_log[1], busy_log[20], busy_log[21]);
        end
        checks++; if (last_type !== EXP_TYPE) begin errors++; $display("FAIL clean_req_type: got %0d want %0d", last_type, EXP_TYPE); end
        checks++; if (got_data.size() !== DEPTH) begin errors++; $display("FAIL clean_count: got %0d want %0d", got_data.size(), DEPTH); end
        for (int i = 0; i < DEPTH && i < got_data.size(); i++) begin
            checks++; if (got_addr[i] !== AW'(i) || got_data[i] !== 8'(i)) begin
                errors++; $display("FAIL clean_code[%0d]: got addr %0d data %h want addr %0d data %h", i, got_addr[i], got_data[i], i, 8'(i));
            end
        end
        nd = 0;
        foreach (got_dis[i]) if (got_dis[i]) nd++;
        checks++; if (nd !== 0) begin errors++; $display("FAIL clean_disabled: got %0d flagged want 0", nd); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL clean_done_pulses: got %0d want 1", done_cnt); end
    endtask

    task automatic test_backpressure();
        int d;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'h40 + i);
        gen++;
        do_sweep(1, -1, d);
        checks++; if (max_out > FIFO_DEPTH) begin errors++; $display("FAIL bp_credit: got %0d outstanding want <= %0d", max_out, FIFO_DEPTH); end
        checks++; if (d !== 30) begin errors++; $display("FAIL bp_done_cycle: got %0d want 30", d); end
        checks++; if (got_data.size() !== DEPTH) begin errors++; $display("FAIL bp_count: got %0d want %0d", got_data.size(), DEPTH); end
        for (int i = 0; i < DEPTH && i < got_data.size(); i++) begin
            checks++; if (got_addr[i] !== AW'(i) || got_data[i] !== 8'(8'h40 + i)) begin
                errors++; $display("FAIL bp_code[%0d]: got addr %0d data %h want addr %0d data %h", i, got_addr[i], got_data[i], i, 8'(8'h40 + i));
            end
        end
    endtask

    task automatic test_disabled();
        int d;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i * 3 + 1);
        mem[5] = 8'hFF;
        gen++;
        do_sweep(0, -1, d);
        checks++; if (got_dis.size() !== DEPTH) begin errors++; $display("FAIL dis_count: got %0d want %0d", got_dis.size(), DEPTH); end
        for (int i = 0; i < DEPTH && i < got_dis.size(); i++) begin
            checks++; if (got_dis[i] !== (i == 5) || got_data[i] !== ((i == 5) ? 8'hFF : 8'(i * 3 + 1))) begin
                errors++; $display("FAIL dis_code[%0d]: got flag %b data %h want flag %b", i, got_dis[i], got_data[i], (i == 5));
            end
        end
    endtask

    task automatic test_foreign_traffic();
        int d;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'h80 + i);
        gen++;
        foreign_en = 1'b1;
        do_sweep(2, -1, d);
        foreign_en = 1'b0;
        checks++; if (got_data.size() !== DEPTH) begin errors++; $display("FAIL foreign_count: got %0d want %0d", got_data.size(), DEPTH); end
        checks++; if (max_out > FIFO_DEPTH) begin errors++; $display("FAIL foreign_credit: got %0d outstanding want <= %0d", max_out, FIFO_DEPTH); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL foreign_done_pulses: got %0d want 1", done_cnt); end
        for (int i = 0; i < DEPTH && i < got_data.size(); i++) begin
            checks++; if (got_addr[i] !== AW'(i) || got_data[i] !== 8'(8'h80 + i)) begin
                errors++; $display("FAIL foreign_code[%0d]: got addr %0d data %h want addr %0d data %h", i, got_addr[i], got_data[i], i, 8'(8'h80 + i));
            end
        end
    endtask

    task automatic test_back_to_back();
        int d;
        logic [WIDTH-1:0] exp2;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'h20 + i);
        gen++;
        do_sweep(0, -1, d);
        checks++; if (got_data.size() !== DEPTH) begin errors++; $display("FAIL b2b_first_count: got %0d want %0d", got_data.size(), DEPTH); end
        for (int i = 0; i < DEPTH && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== 8'(8'h20 + i)) begin
                errors++; $display("FAIL b2b_first[%0d]: got %h want %h", i, got_data[i], 8'(8'h20 + i));
            end
        end
        do_sweep(0, -1, d);
        checks++; if (d !== 20) begin errors++; $display("FAIL b2b_second_done: got %0d want 20", d); end
        checks++; if (got_data.size() !== DEPTH) begin errors++; $display("FAIL b2b_second_count: got %0d want %0d", got_data.size(), DEPTH); end
        for (int i = 0; i < DEPTH && i < got_data.size(); i++) begin
`ifdef SCAN_CLEAR_ON_READ_EN
            exp2 = '0;
`else
            exp2 = 8'(8'h20 + i);
`endif
            checks++; if (got_data[i] !== exp2 || got_addr[i] !== AW'(i)) begin
                errors++; $display("FAIL b2b_second[%0d]: got addr %0d data %h want addr %0d data %h", i, got_addr[i], got_data[i], i, exp2);
            end
        end
    endtask

    task automatic test_reset_restart();
        int d, bad;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i + 1);
        gen++;
        @(posedge clk); #1;
        start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_in = 1'b0;
        #1;
        checks++; if (busy_out !== 1'b0 || req_valid_out !== 1'b0 || done_out !== 1'b0) begin
            errors++; $display("FAIL midreset_ctrl: busy %b req_valid %b done %b want 0 0 0", busy_out, req_valid_out, done_out);
        end
        checks++; if (code_valid_out !== 1'b0 || code_out !== '0 || code_addr_out !== '0) begin
            errors++; $display("FAIL midreset_code: valid %b data %h addr %0d want 0 0 0", code_valid_out, code_out, code_addr_out);
        end
        @(posedge clk); #1;
        rst_in = 1'b1;
        bad = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (code_valid_out || busy_out || req_valid_out) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stale_returns: got %0d active cycles want 0", bad); end
        do_sweep(0, 10, d);
        checks++; if (d !== 20) begin errors++; $display("FAIL restart_done: got %0d want 20", d); end
        checks++; if (done_cnt !== 1 || busy_out !== 1'b0) begin
            errors++; $display("FAIL busy_start_ignored: done pulses %0d busy %b want 1 0", done_cnt, busy_out);
        end
        checks++; if (got_data.size() !== DEPTH) begin errors++; $display("FAIL restart_count: got %0d want %0d", got_data.size(), DEPTH); end
        for (int i = 0; i < DEPTH && i < got_data.size(); i++) begin
            checks++; if (got_addr[i] !== AW'(i) || got_data[i] !== 8'(i + 1)) begin
                errors++; $display("FAIL restart_code[%0d]: got addr %0d data %h want addr %0d data %h", i, got_addr[i], got_data[i], i, 8'(i + 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_sweep();
        test_backpressure();
        test_disabled();
        test_foreign_traffic();
        test_back_to_back();
        test_reset_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/accum_ram_scanner.md
# accum_ram_scanner

Request-side initiator and read-out engine for `shift_accum_ram`. On a start pulse it sweeps every address of the accumulator and issues one request per cycle on the RAM's request port. It captures the returned words 2 cycles later and delivers them as a valid/ready stream of (address, code) pairs to the downstream LED-ID decoder. Credit-based flow control guarantees that no returned word is ever dropped under backpressure.

## Interface
Parameters:
- `WIDTH`, 8: accumulator word width; must match the RAM.
- `DEPTH`, 256: number of accumulator entries; must match the RAM.
- `FIFO_DEPTH`, 4: result buffer entries; power of two, ≥ 4.

Ports:
- `clk_in`  in  1  single clock.
- `rst_in`  in  1  reset, asynchronous, active-low.
- `start_in`  in  1  one-cycle pulse that begins a sweep; ignored while `busy_out`.
- `busy_out`  out  1  high from the cycle after an accepted start until the `done_out` cycle, inclusive.
- `done_out`  out  1  one-cycle pulse when the sweep has fully drained.
- `req_addr_out`  out  clog2(DEPTH)  RAM `addr_in`.
- `req_type_out`  out  accum_request_t  RAM `request_type_in`.
- `req_summand_out`  out  1  RAM `summand_in`; always 0.
- `req_valid_out`  out  1  RAM `request_valid_in`.
- `ret_data_in`  in  WIDTH  RAM `read_out`.
- `ret_addr_in`  in  clog2(DEPTH)  RAM `addr_out`.
- `ret_type_in`  in  accum_request_t  RAM `request_type_out`.
- `ret_valid_in`  in  1  RAM `result_valid_out`.
- `code_out`  out  WIDTH  returned accumulator word.
- `code_addr_out`  out  clog2(DEPTH)  address of `code_out`.
- `code_disabled_out`  out  1  high when `code_out` is all-ones (disabled lockout).
- `code_valid_out`  out  1  stream valid.
- `code_ready_in`  in  1  stream ready.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: on `start_in`, clear the address counter to 0 and go to ISSUE.
  - ISSUE: each cycle with credit available, drive `req_valid_out`=1 at the counter address, then increment the counter. After issuing address DEPTH-1, go to DRAIN.
  - DRAIN: when in-flight = 0 and the FIFO is empty, go to DONE.
  - DONE: `done_out`=1 for one cycle, then IDLE.
- Credit rule:
  - Issue only when in_flight + fifo_count < FIFO_DEPTH.
  - in_flight is a 2-bit counter: +1 on issue, −1 on capture. Both in the same cycle leave it unchanged.
- Capture rule:
  - Push {`ret_data_in`, `ret_addr_in`} into the FIFO when `ret_valid_in` and `ret_type_in` equals this block's request type.
  - Returns of any other type come from other initiators on the shared RAM. Ignore them; they do not touch credit.
- Stream rule:
  - Pop when `code_valid_out && code_ready_in`.
  - Push and pop in the same cycle keep the count unchanged.
  - `code_valid_out` must not depend combinationally on `code_ready_in`.
  - Once asserted, data holds stable until accepted.
- `code_disabled_out` = (`code_out` == all-ones).
- The address counter is clog2(DEPTH)+1 bits, so reaching DEPTH is detected without wrap.
- `start_in` while busy is ignored. It is not queued.
- Reset mid-sweep:
  - All state, counters and the FIFO clear immediately.
  - Returns arriving after reset release are ignored because in_flight = 0 and the FSM is IDLE.
- Reset values: all outputs 0. `req_type_out` resets to READ.

## Timing
- `start_in` at cycle 0 → first request at cycle 1.
- The RAM returns at request + 2.
- Capture occurs on the return edge; `code_valid_out` rises at request + 3.
- With `code_ready_in` held high: one code per cycle, no bubbles, `done_out` at cycle DEPTH+4.
- `req_valid_out` is a registered output; all request fields change together.

## Configuration
- `SCAN_CLEAR_ON_READ_EN` defined:
  - Requests are issued as WRITE_OVER with summand 0. The RAM returns the old word and zeroes the entry (read-first).
  - Capture matches WRITE_OVER.
- Not defined:
  - Requests are issued as READ and the RAM contents are untouched.
  - Capture matches READ.

## Structure
- Move `accum_request_t` (READ, WRITE, WRITE_OVER, DISABLE) out of the RAM file into a shared package, `accum_pkg`, imported by both blocks.
- The package also holds the `RAM_READ_LATENCY` = 2 constant.
- One sub-module: `accum_result_fifo`, a synchronous FIFO with count output and registered outputs.
- The FSM, credit logic and address counter stay in the top level.

## Test plan
- **Clean sweep:** DEPTH=16, RAM preloaded with entry i = i, ready always 1, start pulse → 16 codes, addresses 0..15, values 0..15, `done_out` at cycle 20.
- **Backpressure:** ready low for 10 cycles mid-sweep → at most FIFO_DEPTH outstanding (credit never exceeded), no loss or duplication, order preserved.
- **Disabled entries:** entry 5 = 0xFF with WIDTH=8 → `code_disabled_out`=1 on address 5 only.
- **Foreign traffic:** interleave WRITE returns from another initiator → ignored, credit unaffected, output count still 16.
- **Clear-on-read:** with `SCAN_CLEAR_ON_READ_EN`, two back-to-back sweeps → second sweep returns all zeros.
- **Reset and re-start:** assert `rst_in` low at cycle 8 of a sweep → outputs 0 immediately; start after release → full clean sweep. A `start_in` pulse while busy has no effect.
